seq_mul: RTL and testbench

- Parametrised sequential successor to the team's 8-bit combinational multiplier.
- Computes an N x N product iteratively. Each cycle retires one DIGIT-bit slice of operand b using a WIDTH x DIGIT partial-product row.
- Adds a signed/unsigned mode and valid/ready handshakes, trading area for latency.
- Sits between the datapath register stage and its consumer in the arithmetic unit.

---
 rtl/seq_mul_pkg.sv | 21 ++
 rtl/seq_mul_if.sv | 28 ++
 rtl/seq_mul_pp_row.sv | 16 +
 rtl/seq_mul.sv | 109 ++++++++++
 tb/tb_seq_mul.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential multiplier.
//   state_t    : controller states (IDLE, CALC, DONE)
//   nsteps()   : number of DIGIT-bit slices of b in a WIDTH-bit operand (WIDTH/DIGIT)
//   cnt_width(): width of the step counter, clog2(NSTEPS) with a minimum of 1
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int unsigned nsteps(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Operand / product handshake bundle for seq_mul.
//   in_valid, in_ready     : operand handshake (master -> slave)
//   a, b, signed_mode      : operands and mode, sampled on in_valid & in_ready
//   out_valid, out_ready   : product handshake (slave -> master)
//   m                      : 2*WIDTH-bit product
// master = producer/consumer side, slave = the multiplier.
interface seq_mul_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   signed_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     m;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, m
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, m
    );
endinterface

// File: rtl/seq_mul_pp_row.sv
// pp_row: combinational unsigned WIDTH x DIGIT partial-product row.
//   a : WIDTH-bit unsigned multiplicand
//   d : DIGIT-bit unsigned slice of the multiplier
//   p : WIDTH+DIGIT-bit product a * d (always fits, no truncation)
module pp_row #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 4
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [DIGIT-1:0]       d,
    output logic [WIDTH+DIGIT-1:0] p
);

    assign p = {{DIGIT{1'b0}}, a} * {{WIDTH{1'b0}}, d};

endmodule

// File: rtl/seq_mul.sv
// seq_mul: iterative WIDTH x WIDTH multiplier, one DIGIT-bit slice of b per cycle.
// Signed operation is done on magnitudes with the sign restored at the end.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset, discards any operation in flight
//   bus : seq_mul_if slave port (operand in, product out, valid/ready on each)
// Latency from operand accept to out_valid is WIDTH/DIGIT cycles.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    seq_mul_if.slave   bus
);

    localparam int unsigned NSTEPS = nsteps(WIDTH, DIGIT);
    localparam int unsigned CW     = cnt_width(NSTEPS);
    localparam int unsigned PW     = 2 * WIDTH;

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $fatal(1, "seq_mul: DIGIT must be >= 1 and divide WIDTH");
    end

    state_t                 state;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic                   neg;
    logic [CW-1:0]          step;
    logic [PW-1:0]          acc;
    logic [PW-1:0]          m_r;
    logic                   in_ready_r;
    logic                   out_valid_r;

    logic [WIDTH-1:0]       abs_a;
    logic [WIDTH-1:0]       abs_b;
    logic [DIGIT-1:0]       b_slice;
    logic [WIDTH+DIGIT-1:0] pp;
    logic [PW-1:0]          acc_next;

    // Negating the most negative value wraps back onto itself, which read
    // as unsigned is exactly its magnitude 2^(WIDTH-1).
    assign abs_a = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign b_slice = DIGIT'(mag_b >> (step * DIGIT));

    pp_row #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_pp_row (
        .a (mag_a),
        .d (b_slice),
        .p (pp)
    );

    assign acc_next = acc + (PW'(pp) << (step * DIGIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mag_a       <= '0;
            mag_b       <= '0;
            neg         <= 1'b0;
            step        <= '0;
            acc         <= '0;
            m_r         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_a      <= abs_a;
                        mag_b      <= abs_b;
                        neg        <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc        <= '0;
                        step       <= '0;
                        in_ready_r <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    step <= step + 1'b1;
                    if (step == CW'(NSTEPS - 1)) begin
                        m_r         <= neg ? -acc_next : acc_next;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.m         = m_r;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul. Four configurations are instantiated
// (8/4, 16/1, 8/2, 8/8) and driven from one shared stimulus set, with sel
// choosing which instance sees the handshakes. Products are checked against
// plain integer multiplication of the sign-interpreted operands.
module tb_seq_mul;

    logic        clk;
    logic        rst;
    int          sel;
    logic        in_valid_d;
    logic [15:0] a_d;
    logic [15:0] b_d;
    logic        sm_d;
    logic        out_ready_d;

    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] m_o;

    int n_checks;
    int n_fail;

    seq_mul_if #(.WIDTH(8))  if0 ();
    seq_mul_if #(.WIDTH(16)) if1 ();
    seq_mul_if #(.WIDTH(8))  if2 ();
    seq_mul_if #(.WIDTH(8))  if3 ();

    seq_mul #(.WIDTH(8),  .DIGIT(4)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    seq_mul #(.WIDTH(16), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    seq_mul #(.WIDTH(8),  .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    seq_mul #(.WIDTH(8),  .DIGIT(8)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    assign if0.in_valid    = in_valid_d && (sel == 0);
    assign if1.in_valid    = in_valid_d && (sel == 1);
    assign if2.in_valid    = in_valid_d && (sel == 2);
    assign if3.in_valid    = in_valid_d && (sel == 3);
    assign if0.out_ready   = out_ready_d && (sel == 0);
    assign if1.out_ready   = out_ready_d && (sel == 1);
    assign if2.out_ready   = out_ready_d && (sel == 2);
    assign if3.out_ready   = out_ready_d && (sel == 3);
    assign if0.a = a_d[7:0];
    assign if0.b = b_d[7:0];
    assign if1.a = a_d;
    assign if1.b = b_d;
    assign if2.a = a_d[7:0];
    assign if2.b = b_d[7:0];
    assign if3.a = a_d[7:0];
    assign if3.b = b_d[7:0];
    assign if0.signed_mode = sm_d;
    assign if1.signed_mode = sm_d;
    assign if2.signed_mode = sm_d;
    assign if3.signed_mode = sm_d;

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        m_o         = '0;
        case (sel)
            0: begin in_ready_o = if0.in_ready; out_valid_o = if0.out_valid; m_o = 32'(if0.m); end
            1: begin in_ready_o = if1.in_ready; out_valid_o = if1.out_valid; m_o = 32'(if1.m); end
            2: begin in_ready_o = if2.in_ready; out_valid_o = if2.out_valid; m_o = 32'(if2.m); end
            3: begin in_ready_o = if3.in_ready; out_valid_o = if3.out_valid; m_o = 32'(if3.m); end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 1) ? 16 : 8;
    endfunction

    function automatic int steps_of(input int s);
        case (s)
            0:       return 2;
            1:       return 16;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    // Reference: interpret operands per mode, multiply, reduce mod 2^(2w).
    function automatic longint ref_prod(input int w, input longint av, input longint bv, input bit sm);
        longint sa;
        longint sb;
        longint mask;
        sa = av;
        sb = bv;
        if (sm && av[w-1]) sa = av - (longint'(1) << w);
        if (sm && bv[w-1]) sb = bv - (longint'(1) << w);
        mask = (longint'(1) << (2 * w)) - 1;
        return (sa * sb) & mask;
    endfunction

    // One full transaction on instance s: accept, wait for the product,
    // hold it under backpressure for 'stall' cycles (optionally offering a
    // bogus operand meanwhile), then release and confirm return to idle.
    task automatic run_op(input int s, input longint av, input longint bv, input bit sm,
                          input int stall, input bit poke, output longint mo);
        int guard;
        int lat;
        int bad_rdy;
        int bad_hold;
        sel = s;
        guard = 0;
        while (!in_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", longint'(in_ready_o), 1);
        a_d = 16'(av);
        b_d = 16'(bv);
        sm_d = sm;
        out_ready_d = 1'b0;
        in_valid_d = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_d = 1'b0;
        lat = 0;
        bad_rdy = 0;
        while (!out_valid_o && lat < 64) begin
            if (in_ready_o) bad_rdy++;
            @(negedge clk);
            lat++;
        end
        check("latency", longint'(lat), longint'(steps_of(s)));
        check("busy_in_ready", longint'(bad_rdy), 0);
        mo = longint'(m_o);
        check("product_model", mo, ref_prod(width_of(s), av, bv, sm));
        bad_hold = 0;
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                a_d = 16'h0011;
                in_valid_d = 1'b1;
            end
            @(negedge clk);
            if (longint'(m_o) != mo || !out_valid_o || in_ready_o) bad_hold++;
        end
        check("hold_stable", longint'(bad_hold), 0);
        in_valid_d = 1'b0;
        out_ready_d = 1'b1;
        @(negedge clk);
        out_ready_d = 1'b0;
        check("release_out_valid", longint'(out_valid_o), 0);
        check("release_in_ready", longint'(in_ready_o), 1);
    endtask

    initial begin
        longint mo;
        n_checks = 0;
        n_fail = 0;
        sel = 0;
        in_valid_d = 1'b0;
        a_d = '0;
        b_d = '0;
        sm_d = 1'b0;
        out_ready_d = 1'b0;
        rst = 1'b1;
        #1;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check("reset_in_ready", longint'(in_ready_o), 1);
            check("reset_out_valid", longint'(out_valid_o), 0);
            check("reset_m", longint'(m_o), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 8x8, DIGIT=4 directed cases
        run_op(0, 'hFF, 'hFF, 1'b0, 0, 1'b0, mo);
        check("u_ff_ff", mo, 'hFE01);
        run_op(0, 'h80, 'h80, 1'b1, 1, 1'b0, mo);
        check("s_80_80", mo, 'h4000);
        run_op(0, 'hFF, 'h01, 1'b1, 0, 1'b0, mo);
        check("s_ff_01", mo, 'hFFFF);
        run_op(0, 'h80, 'h01, 1'b1, 2, 1'b0, mo);
        check("s_80_01", mo, 'hFF80);
        run_op(0, 'h80, 'h01, 1'b0, 0, 1'b0, mo);
        check("u_80_01", mo, 'h0080);

        // Backpressure with an operand offered while the product is held
        run_op(0, 'h12, 'h34, 1'b0, 5, 1'b1, mo);
        check("bp_product", mo, 'h03A8);
        @(negedge clk);
        check("bp_no_capture", longint'(out_valid_o), 0);
        check("bp_idle_ready", longint'(in_ready_o), 1);

        // Reset in the middle of a calculation
        sel = 0;
        a_d = 16'h0077;
        b_d = 16'h0055;
        sm_d = 1'b0;
        in_valid_d = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_d = 1'b0;
        @(posedge clk);
        #2;
        check("midcalc_busy", longint'(in_ready_o), 0);
        rst = 1'b1;
        #1;
        check("rst_out_valid", longint'(out_valid_o), 0);
        check("rst_m", longint'(m_o), 0);
        check("rst_in_ready", longint'(in_ready_o), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(0, 3, 5, 1'b0, 0, 1'b0, mo);
        check("post_rst_3x5", mo, 15);

        // 16x16, DIGIT=1
        run_op(1, 'hFFFF, 'hFFFF, 1'b0, 0, 1'b0, mo);
        check("w16_u_ffff", mo, 'hFFFE0001);
        run_op(1, 'hFFFE, 'h0003, 1'b1, 1, 1'b0, mo);
        check("w16_s_fffe_3", mo, 'hFFFFFFFA);

        // Randomised traffic on DIGIT=2 and DIGIT=8
        for (int s = 2; s < 4; s++) begin
            for (int n = 0; n < 2000; n++) begin
                run_op(s, longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0), mo);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
